// File: rtl/nmr_bstrm_pkg.sv
// Shared types for the NMR bitstream sequencer: opcodes, command field offsets, FSM states.
// Hardware looping is enabled by defining NMR_BSTRM_SEQ_LOOP_EN.
package nmr_bstrm_pkg;

  typedef enum logic [2:0] {
    OP_PULSE      = 3'd0,
    OP_LOOP_BEGIN = 3'd1,
    OP_LOOP_END   = 3'd2,
    OP_HALT       = 3'd3
  } op_e;

  // Field offsets above the payload, i.e. relative to bit DATA_WIDTH.
  localparam int MUX_OFS = 0;
  localparam int MUX_W   = 4;
  localparam int POL_OFS = 4;
  localparam int OP_OFS  = 5;
  localparam int OP_W    = 3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_WAIT    = 4'd2,
    S_DECODE  = 4'd3,
    S_ISSUE   = 4'd4,
    S_ARMED   = 4'd5,
    S_RUN     = 4'd6,
    S_RELEASE = 4'd7,
    S_FINISH  = 4'd8
  } state_e;

endpackage

// File: rtl/nmr_bstrm_seq_decode.sv
// Combinational split of a program command word into its fields plus an opcode legality flag.
// Independent of NMR_BSTRM_SEQ_LOOP_EN; loop opcodes are always legal here.
module nmr_bstrm_seq_decode
  import nmr_bstrm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CMD_WIDTH  = DATA_WIDTH + 8
) (
  input  logic [CMD_WIDTH-1:0]  i_cmd,
  output logic [DATA_WIDTH-1:0] o_payload,
  output logic [MUX_W-1:0]      o_mux_sel,
  output logic                  o_pol,
  output logic [OP_W-1:0]       o_opcode,
  output logic                  o_illegal
);

  assign o_payload = i_cmd[DATA_WIDTH-1:0];
  assign o_mux_sel = i_cmd[DATA_WIDTH+MUX_OFS +: MUX_W];
  assign o_pol     = i_cmd[DATA_WIDTH+POL_OFS];
  assign o_opcode  = i_cmd[DATA_WIDTH+OP_OFS +: OP_W];
  assign o_illegal = (o_opcode > OP_HALT);

endmodule

// File: rtl/nmr_bstrm_seq_ctrl.sv
// Program-RAM sequencer driving one bitstream datapath through START/DPATH_RDY/DONE, one pulse at a time.
// Define NMR_BSTRM_SEQ_LOOP_EN for single-level hardware looping (LOOP_BEGIN/LOOP_END).
module nmr_bstrm_seq_ctrl
  import nmr_bstrm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CMD_WIDTH  = DATA_WIDTH + 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SEQ_START,
  input  logic [ADDR_WIDTH-1:0] START_ADDR,
  output logic                  SEQ_BUSY,
  output logic                  SEQ_DONE,
  output logic                  SEQ_ERR,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rden,
  input  logic [CMD_WIDTH-1:0]  ram_rdata,
  output logic                  BS_START,
  input  logic                  BS_DPATH_RDY,
  input  logic                  BS_DONE,
  output logic [DATA_WIDTH-1:0] BS_DATA,
  output logic                  BS_PLS_POL,
  output logic [3:0]            BS_MUX_SEL,
  output logic [3:0]            o_dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ONE_D = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_e                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [CMD_WIDTH-1:0]    r_cmd;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_pol;
  logic [3:0]              r_mux;
  logic                    r_err;

  logic [DATA_WIDTH-1:0]   w_payload;
  logic [3:0]              w_mux;
  logic                    w_pol;
  logic [2:0]              w_opcode;
  logic                    w_illegal;
  logic                    w_nest_err;
  logic                    w_stop;
  logic                    w_issue;
  logic [ADDR_WIDTH-1:0]   w_pc_inc;
  logic [ADDR_WIDTH-1:0]   w_pc_next;

  nmr_bstrm_seq_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .CMD_WIDTH  (CMD_WIDTH)
  ) u_decode (
    .i_cmd      (r_cmd),
    .o_payload  (w_payload),
    .o_mux_sel  (w_mux),
    .o_pol      (w_pol),
    .o_opcode   (w_opcode),
    .o_illegal  (w_illegal)
  );

  // pc wraps naturally at 2^ADDR_WIDTH.
  assign w_pc_inc = r_pc + ONE_A;
  assign w_stop   = w_illegal || w_nest_err || (w_opcode == OP_HALT);
  assign w_issue  = (w_opcode == OP_PULSE) && (w_payload != '0);

`ifdef NMR_BSTRM_SEQ_LOOP_EN
  logic                  r_loop_active;
  logic [ADDR_WIDTH-1:0] r_loop_addr;
  logic [DATA_WIDTH-1:0] r_loop_cnt;
  logic                  w_loop_back;

  assign w_nest_err  = (w_opcode == OP_LOOP_BEGIN) && r_loop_active;
  // Count is always >= 1 while active, so "decrement is nonzero" means "count != 1".
  assign w_loop_back = (w_opcode == OP_LOOP_END) && r_loop_active && (r_loop_cnt != ONE_D);
  assign w_pc_next   = w_loop_back ? r_loop_addr : w_pc_inc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_loop_active <= 1'b0;
      r_loop_addr   <= '0;
      r_loop_cnt    <= '0;
    end else if (r_state == S_IDLE && SEQ_START) begin
      r_loop_active <= 1'b0;
    end else if (r_state == S_DECODE) begin
      if (w_opcode == OP_LOOP_BEGIN && !r_loop_active) begin
        r_loop_active <= 1'b1;
        r_loop_addr   <= w_pc_inc;
        r_loop_cnt    <= (w_payload == '0) ? ONE_D : w_payload;
      end else if (w_opcode == OP_LOOP_END && r_loop_active) begin
        r_loop_cnt <= r_loop_cnt - ONE_D;
        if (r_loop_cnt == ONE_D) r_loop_active <= 1'b0;
      end
    end
  end
`else
  assign w_nest_err = 1'b0;
  assign w_pc_next  = w_pc_inc;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Handshake: START rises after DPATH_RDY, stays up until DONE has been seen low then high,
  // and the next command is only fetched once DPATH_RDY returns with START low.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (SEQ_START) w_next = S_FETCH;
      S_FETCH:   w_next = S_WAIT;
      S_WAIT:    w_next = S_DECODE;
      S_DECODE: begin
        if (w_stop)       w_next = S_FINISH;
        else if (w_issue) w_next = S_ISSUE;
        else              w_next = S_FETCH;
      end
      S_ISSUE:   if (BS_DPATH_RDY) w_next = S_ARMED;
      S_ARMED:   if (!BS_DONE)     w_next = S_RUN;
      S_RUN:     if (BS_DONE)      w_next = S_RELEASE;
      S_RELEASE: if (BS_DPATH_RDY) w_next = S_FETCH;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc   <= '0;
      r_cmd  <= '0;
      r_data <= '0;
      r_pol  <= 1'b0;
      r_mux  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (SEQ_START) begin
            r_pc  <= START_ADDR;
            r_err <= 1'b0;
          end
        end
        S_WAIT: r_cmd <= ram_rdata;
        S_DECODE: begin
          if (w_illegal || w_nest_err) begin
            r_err <= 1'b1;
          end else if (w_issue) begin
            r_data <= w_payload;
            r_pol  <= w_pol;
            r_mux  <= w_mux;
          end else if (!w_stop) begin
            r_pc <= w_pc_next;
          end
        end
        S_RELEASE: if (BS_DPATH_RDY) r_pc <= w_pc_inc;
        default: ;
      endcase
    end
  end

  assign SEQ_BUSY    = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign SEQ_DONE    = (r_state == S_FINISH);
  assign SEQ_ERR     = r_err;
  assign ram_addr    = r_pc;
  assign ram_rden    = (r_state == S_FETCH);
  assign BS_START    = (r_state == S_ARMED) || (r_state == S_RUN);
  assign BS_DATA     = r_data;
  assign BS_PLS_POL  = r_pol;
  assign BS_MUX_SEL  = r_mux;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nmr_bstrm_seq_ctrl.sv
// Bench for nmr_bstrm_seq_ctrl with a behavioural program RAM and bitstream datapath.
// Loop programs are exercised differently depending on NMR_BSTRM_SEQ_LOOP_EN.
module tb_nmr_bstrm_seq_ctrl;
  import nmr_bstrm_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = DW + 8;

  logic          clk, rst;
  logic          seq_start;
  logic [AW-1:0] start_addr;
  logic          seq_busy, seq_done, seq_err;
  logic [AW-1:0] ram_addr;
  logic          ram_rden;
  logic [CW-1:0] ram_q;
  logic          bs_start, dp_rdy, dp_done, dp_out, dp_busy;
  logic [DW-1:0] bs_data, dp_cnt;
  logic          bs_pol;
  logic [3:0]    bs_mux;
  logic [3:0]    dbg_state;

  logic [CW-1:0] ram [0:(1<<AW)-1];
  logic [36:0]   exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_starts, n_dones, stab_err;
  logic [31:0] cur_len;
  int out_cnt;
  logic prev_start, prev_out, prev_done, in_win;
  logic [36:0] held, exp_e;

  nmr_bstrm_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK          (clk),
    .RST          (rst),
    .SEQ_START    (seq_start),
    .START_ADDR   (start_addr),
    .SEQ_BUSY     (seq_busy),
    .SEQ_DONE     (seq_done),
    .SEQ_ERR      (seq_err),
    .ram_addr     (ram_addr),
    .ram_rden     (ram_rden),
    .ram_rdata    (ram_q),
    .BS_START     (bs_start),
    .BS_DPATH_RDY (dp_rdy),
    .BS_DONE      (dp_done),
    .BS_DATA      (bs_data),
    .BS_PLS_POL   (bs_pol),
    .BS_MUX_SEL   (bs_mux),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- program RAM: one-cycle read latency ----------------
  always @(posedge clk) if (ram_rden) ram_q <= ram[ram_addr];

  // ---------------- datapath: DONE idles high, OUT high for BS_DATA cycles ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_rdy <= 1'b1; dp_done <= 1'b1; dp_out <= 1'b0; dp_busy <= 1'b0; dp_cnt <= '0;
    end else if (!dp_busy) begin
      if (bs_start && dp_rdy) begin
        dp_busy <= 1'b1; dp_rdy <= 1'b0; dp_done <= 1'b0; dp_out <= 1'b1; dp_cnt <= bs_data;
      end else if (!bs_start && !dp_rdy) begin
        dp_rdy <= 1'b1;
      end
    end else begin
      if (dp_cnt == 32'd1) begin
        dp_out <= 1'b0; dp_done <= 1'b1; dp_busy <= 1'b0;
      end
      dp_cnt <= dp_cnt - 32'd1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0; prev_out = 1'b0; prev_done = 1'b1; in_win = 1'b0; out_cnt = 0;
    end else begin
      if (bs_start && !prev_start) begin
        n_starts++;
        if (exp_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          exp_e   = exp_q.pop_front();
          cur_len = exp_e[31:0];
          check("pulse_fields", {27'd0, bs_pol, bs_mux, bs_data}, {27'd0, exp_e});
        end
        held   = {bs_pol, bs_mux, bs_data};
        in_win = 1'b1;
      end else if (in_win) begin
        if ({bs_pol, bs_mux, bs_data} != held) stab_err++;
        if (dp_rdy && !bs_start) in_win = 1'b0;
      end
      if (dp_done && !prev_done) check("start_held_to_done", bs_start, 1);
      if (dp_out) out_cnt++;
      else if (prev_out) begin
        check("pulse_len", out_cnt, cur_len);
        out_cnt = 0;
      end
      if (seq_done) begin
        n_dones++;
        check("done_busy_low", seq_busy, 0);
      end
      prev_start = bs_start; prev_out = dp_out; prev_done = dp_done;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [CW-1:0] mk(input logic [2:0] op, input logic pol,
                                       input logic [3:0] mux, input logic [31:0] d);
    return {op, pol, mux, d};
  endfunction

  task automatic push(input logic pol, input logic [3:0] mux, input logic [31:0] len);
    exp_q.push_back({pol, mux, len});
  endtask

  task automatic clear_ram();
    for (int i = 0; i < (1 << AW); i++) ram[i] = mk(OP_HALT, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic run_prog(input logic [AW-1:0] addr, input int exp_starts, input logic exp_err,
                          input bit poke, input string tag);
    bit got;
    n_starts = 0; n_dones = 0; stab_err = 0;
    @(negedge clk); start_addr = addr; seq_start = 1'b1;
    @(negedge clk); seq_start = 1'b0;
    check({tag, "_busy_after_start"}, seq_busy, 1);
    check({tag, "_err_cleared"}, seq_err, 0);
    got = 1'b0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk);
      if (poke && c == 4) begin start_addr = 10'd500; seq_start = 1'b1; end
      if (poke && c == 5) seq_start = 1'b0;
      if (seq_done) got = 1'b1;
    end
    check({tag, "_done_seen"}, got, 1);
    repeat (3) @(negedge clk);
    check({tag, "_busy_low"}, seq_busy, 0);
    check({tag, "_done_count"}, n_dones, 1);
    check({tag, "_start_count"}, n_starts, exp_starts);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_err"}, seq_err, exp_err);
    check({tag, "_stable"}, stab_err, 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, ns, base;
    logic [31:0] len;
    logic pol;
    logic [3:0] mux;
    bit got;

    rst = 1'b1; seq_start = 1'b0; start_addr = '0;
    clear_ram();
    repeat (3) @(negedge clk);
    check("rst_busy", seq_busy, 0);
    check("rst_done", seq_done, 0);
    check("rst_err", seq_err, 0);
    check("rst_bs_start", bs_start, 0);
    check("rst_rden", ram_rden, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_bs_fields", {bs_pol, bs_mux, bs_data}, 0);
    rst = 1'b0;

    // single pulse, with a SEQ_START poked while busy that must be ignored
    ram[0] = mk(OP_PULSE, 1'b1, 4'd0, 32'd5); ram[1] = mk(OP_HALT, 1'b0, 4'd0, 32'd0);
    push(1'b1, 4'd0, 32'd5);
    run_prog(10'd0, 1, 1'b0, 1'b1, "single");

    // zero-length pulse skipped
    ram[10] = mk(OP_PULSE, 1'b0, 4'd0, 32'd0);
    ram[11] = mk(OP_PULSE, 1'b0, 4'd2, 32'd3);
    ram[12] = mk(OP_HALT, 1'b0, 4'd0, 32'd0);
    push(1'b0, 4'd2, 32'd3);
    run_prog(10'd10, 1, 1'b0, 1'b0, "skip0");

    // illegal opcode at address 1, then a clean run clears the error
    ram[0] = mk(OP_PULSE, 1'b0, 4'd3, 32'd2); ram[1] = mk(3'd5, 1'b0, 4'd0, 32'd0);
    push(1'b0, 4'd3, 32'd2);
    run_prog(10'd0, 1, 1'b1, 1'b0, "illegal");
    push(1'b0, 4'd2, 32'd3);
    run_prog(10'd10, 1, 1'b0, 1'b0, "err_clear");

    // pc wrap 1023 -> 0
    ram[1023] = mk(OP_PULSE, 1'b1, 4'd7, 32'd4); ram[0] = mk(OP_HALT, 1'b0, 4'd0, 32'd0);
    push(1'b1, 4'd7, 32'd4);
    run_prog(10'd1023, 1, 1'b0, 1'b0, "wrap");

    // loop programs
    ram[200] = mk(OP_LOOP_BEGIN, 1'b0, 4'd0, 32'd4);
    ram[201] = mk(OP_PULSE, 1'b0, 4'd1, 32'd2);
    ram[202] = mk(OP_PULSE, 1'b1, 4'd2, 32'd3);
    ram[203] = mk(OP_LOOP_END, 1'b0, 4'd0, 32'd0);
    ram[204] = mk(OP_HALT, 1'b0, 4'd0, 32'd0);
    ram[220] = mk(OP_LOOP_BEGIN, 1'b0, 4'd0, 32'd0);
    ram[221] = mk(OP_PULSE, 1'b0, 4'd1, 32'd2);
    ram[222] = mk(OP_PULSE, 1'b1, 4'd2, 32'd3);
    ram[223] = mk(OP_LOOP_END, 1'b0, 4'd0, 32'd0);
    ram[224] = mk(OP_HALT, 1'b0, 4'd0, 32'd0);
    ram[240] = mk(OP_LOOP_BEGIN, 1'b0, 4'd0, 32'd2);
    ram[241] = mk(OP_LOOP_BEGIN, 1'b0, 4'd0, 32'd1);
    ram[242] = mk(OP_PULSE, 1'b0, 4'd1, 32'd2);
    ram[243] = mk(OP_HALT, 1'b0, 4'd0, 32'd0);
    ram[260] = mk(OP_LOOP_END, 1'b0, 4'd0, 32'd0);
    ram[261] = mk(OP_PULSE, 1'b1, 4'd9, 32'd4);
    ram[262] = mk(OP_HALT, 1'b0, 4'd0, 32'd0);
`ifdef NMR_BSTRM_SEQ_LOOP_EN
    for (int k = 0; k < 4; k++) begin push(1'b0, 4'd1, 32'd2); push(1'b1, 4'd2, 32'd3); end
    run_prog(10'd200, 8, 1'b0, 1'b0, "loop4");
    push(1'b0, 4'd1, 32'd2); push(1'b1, 4'd2, 32'd3);
    run_prog(10'd220, 2, 1'b0, 1'b0, "loop0");
    run_prog(10'd240, 0, 1'b1, 1'b0, "loop_nest");
    push(1'b1, 4'd9, 32'd4);
    run_prog(10'd260, 1, 1'b0, 1'b0, "loop_end_nop");
`else
    push(1'b0, 4'd1, 32'd2); push(1'b1, 4'd2, 32'd3);
    run_prog(10'd200, 2, 1'b0, 1'b0, "loop_nop");
    push(1'b0, 4'd1, 32'd2);
    run_prog(10'd240, 1, 1'b0, 1'b0, "loop_nop_nest");
`endif

    // random short programs
    for (int i = 0; i < 6; i++) begin
      base = 100 + 16 * i;
      n = $urandom_range(1, 4);
      ns = 0;
      for (int j = 0; j < n; j++) begin
        len = $urandom_range(0, 6);
        pol = 1'($urandom_range(0, 1));
        mux = 4'($urandom_range(0, 15));
        ram[base + j] = mk(OP_PULSE, pol, mux, len);
        if (len != 0) begin push(pol, mux, len); ns++; end
      end
      ram[base + n] = mk(OP_HALT, 1'b0, 4'd0, 32'd0);
      run_prog(10'(base), ns, 1'b0, 1'b0, "rand");
    end

    // reset during RUN of a long pulse
    ram[30] = mk(OP_PULSE, 1'b0, 4'd5, 32'd1000); ram[31] = mk(OP_HALT, 1'b0, 4'd0, 32'd0);
    push(1'b0, 4'd5, 32'd1000);
    n_dones = 0;
    @(negedge clk); start_addr = 10'd30; seq_start = 1'b1;
    @(negedge clk); seq_start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (dbg_state == S_RUN) got = 1'b1;
    end
    check("rst_run_reached", got, 1);
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_bs_start", bs_start, 0);
    check("rst_mid_busy", seq_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", n_dones, 0);
    exp_q.delete();

    ram[0] = mk(OP_PULSE, 1'b1, 4'd0, 32'd5); ram[1] = mk(OP_HALT, 1'b0, 4'd0, 32'd0);
    push(1'b1, 4'd0, 32'd5);
    run_prog(10'd0, 1, 1'b0, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nmr_bstrm_seq_ctrl.md
Name: nmr_bstrm_seq_ctrl

Overview:
Upstream sequencer for the NMR bitstream pulse datapath. Fetches command words from an on-chip program RAM and decodes pulse commands into data, polarity and mux-select values. Drives the datapath START/DPATH_RDY/DONE handshake one pulse at a time, with optional single-level hardware looping. Sits between the HPS-loaded program RAM and one bitstream datapath channel.

Parameters:
DATA_WIDTH, 32, pulse length / loop count payload width; must equal datapath DATA_WIDTH
ADDR_WIDTH, 10, program RAM word address width
CMD_WIDTH, DATA_WIDTH+8, command word width (derived; do not override)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
SEQ_START  in  1  1-cycle pulse; begin executing at START_ADDR; ignored unless idle
START_ADDR  in  ADDR_WIDTH  first command address, latched on SEQ_START
SEQ_BUSY  out  1  high from accepted SEQ_START until HALT completes
SEQ_DONE  out  1  1-cycle pulse when HALT retires
SEQ_ERR  out  1  sticky; set on illegal opcode/nesting; cleared by next accepted SEQ_START
ram_addr  out  ADDR_WIDTH  program RAM read address
ram_rden  out  1  program RAM read enable
ram_rdata  in  CMD_WIDTH  RAM read data, valid exactly 1 cycle after ram_rden
BS_START  out  1  to datapath START
BS_DPATH_RDY  in  1  from datapath DPATH_RDY
BS_DONE  in  1  from datapath DONE
BS_DATA  out  DATA_WIDTH  pulse length to datapath
BS_PLS_POL  out  1  pulse polarity to datapath
BS_MUX_SEL  out  4  mux select to datapath

Behaviour:
- Command word fields: [DATA_WIDTH-1:0] payload; [DATA_WIDTH+3:DATA_WIDTH] mux_sel; [DATA_WIDTH+4] pol; [DATA_WIDTH+7:DATA_WIDTH+5] opcode.
- Opcodes: 0 PULSE, 1 LOOP_BEGIN (payload = repeat count), 2 LOOP_END, 3 HALT; opcodes 4-7 illegal.
- Reset values: all outputs 0; state IDLE; loop registers cleared.
- States: IDLE -> FETCH (ram_rden=1, ram_addr=pc) -> WAIT (1-cycle RAM latency) -> DECODE.
- DECODE, PULSE with payload!=0: register BS_DATA/BS_PLS_POL/BS_MUX_SEL from the word, then -> ISSUE.
- DECODE, PULSE with payload==0: skipped, no handshake; pc+1 -> FETCH.
- ISSUE: wait BS_DPATH_RDY=1, then assert BS_START and -> ARMED. ARMED: hold BS_START until BS_DONE=0 (datapath started), then -> RUN. DONE=1 seen in ARMED does not count as completion.
- RUN: hold BS_START until BS_DONE=1, then -> RELEASE. RELEASE: BS_START=0; wait BS_DPATH_RDY=1; pc+1 -> FETCH.
- BS_DATA/BS_PLS_POL/BS_MUX_SEL stay stable from ISSUE through RELEASE.
- HALT: -> FINISH; SEQ_DONE pulses 1 cycle; SEQ_BUSY drops the same cycle; -> IDLE.
- Illegal opcode: set SEQ_ERR, treat as HALT.
- pc increments modulo 2^ADDR_WIDTH; wrap to 0 is legal.
- SEQ_START while busy: ignored.
- RST mid-pulse: BS_START drops asynchronously; in-flight program abandoned; no SEQ_DONE.
- Overhead: 3 cycles fetch/decode per command plus handshake; no prefetch.

Optional Feature:
- Macro: NMR_BSTRM_SEQ_LOOP_EN.
- Defined: LOOP_BEGIN latches loop_addr=pc+1 and loop_cnt=payload (0 is treated as 1). LOOP_END decrements loop_cnt; if the result is nonzero, pc<=loop_addr, else pc+1.
- Defined, errors: LOOP_BEGIN while a loop is active sets SEQ_ERR and halts. LOOP_END with no loop active is a NOP.
- Not defined: opcodes 1 and 2 are NOPs (pc+1); no loop registers are synthesised.

Decomposition:
- Package nmr_bstrm_pkg: opcode enum (OP_PULSE, OP_LOOP_BEGIN, OP_LOOP_END, OP_HALT), field offset localparams, state enum.
- One sub-module, nmr_bstrm_seq_decode: combinational field split plus opcode legality check. The FSM stays in the top module.

Test Plan:
- Program {PULSE len=5 pol=1 mux=0, HALT} with the real datapath -> exactly one BS_START assertion, datapath OUT high for the programmed length, SEQ_DONE one pulse, SEQ_BUSY low afterwards.
- Program {PULSE len=0, PULSE len=3 mux=2, HALT} -> one handshake only; BS_MUX_SEL=2 stable through RELEASE.
- LOOP_EN defined, {LOOP_BEGIN 4, PULSE 2, PULSE 3, LOOP_END, HALT} -> 8 pulses alternating 2/3; LOOP_BEGIN 0 -> 2 pulses.
- Opcode 5 at address 1 -> SEQ_ERR=1 and SEQ_DONE; next SEQ_START clears SEQ_ERR.
- START_ADDR=1023 with ADDR_WIDTH=10, PULSE at 1023 and HALT at 0 -> pc wraps to 0 and the program completes.
- RST asserted during RUN of a len=1000 pulse -> BS_START=0 immediately, SEQ_BUSY=0, no SEQ_DONE; a subsequent SEQ_START runs normally.
